// File: rtl/adc_spi_capture.sv
// adc_spi_capture
//   Reads a 12-bit serial ADC over a 3-wire SPI link at a fixed frame rate.
//   A free-running divider paces frames. Each frame lowers CS_N, clocks in
//   16 bits MSB-first on SCLK rising edges, then presents the low 12 bits as
//   a one-cycle strobe.
//
// Parameters
//   CLK_FREQ   system clock frequency in Hz
//   SAMP_RATE  conversion rate in Hz (PERIOD = CLK_FREQ/SAMP_RATE clocks)
//   SCLK_HALF  clocks per SCLK half-period
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous active-low reset
//   en_i            permits a new frame at the next tick
//   adc_sdata_i     ADC serial data (changes on SCLK falling edges)
//   adc_cs_n_o      ADC chip select, active low
//   adc_sclk_o      ADC serial clock, idles high
//   sample_o        last captured 12-bit raw code
//   sample_valid_o  one-cycle strobe for a new sample_o
//   frame_err_o     one-cycle strobe with sample_valid_o when the leading
//                   four bits of the frame were non-zero
module adc_spi_capture #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned SAMP_RATE = 1_000_000,
  parameter int unsigned SCLK_HALF = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        adc_sdata_i,
  output logic        adc_cs_n_o,
  output logic        adc_sclk_o,
  output logic [11:0] sample_o,
  output logic        sample_valid_o,
  output logic        frame_err_o
);

  localparam int unsigned PERIOD = CLK_FREQ / SAMP_RATE;
  localparam int unsigned TW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned PH_W   = $clog2(2 * SCLK_HALF);

  localparam logic [TW-1:0]   TCNT_LAST = TW'(PERIOD - 1);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(2 * SCLK_HALF - 1);
  localparam logic [PH_W-1:0] PH_RISE   = PH_W'(SCLK_HALF);

  // A frame plus the minimum CS_N high time must fit in one period, which
  // also guarantees a tick never lands outside IDLE.
  if (PERIOD < 32 * SCLK_HALF + 3) begin : g_period_check
    $error("adc_spi_capture: PERIOD must be >= 32*SCLK_HALF + 3");
  end

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT} state_t;

  state_t          state, state_d;
  logic [TW-1:0]   tcnt;
  logic            tick;
  logic [3:0]      bit_cnt, bit_cnt_d;
  logic [PH_W-1:0] ph, ph_d;
  logic [15:0]     shift, shift_d;
  logic            cs_n_d, sclk_d, valid_d, err_d;
  logic [11:0]     sample_d;

  // Free-running frame divider, independent of en_i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt <= '0;
    end else if (tcnt == TCNT_LAST) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  assign tick = (tcnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      ph             <= '0;
      shift          <= '0;
      adc_cs_n_o     <= 1'b1;
      adc_sclk_o     <= 1'b1;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      frame_err_o    <= 1'b0;
    end else begin
      state          <= state_d;
      bit_cnt        <= bit_cnt_d;
      ph             <= ph_d;
      shift          <= shift_d;
      adc_cs_n_o     <= cs_n_d;
      adc_sclk_o     <= sclk_d;
      sample_o       <= sample_d;
      sample_valid_o <= valid_d;
      frame_err_o    <= err_d;
    end
  end

  // All outputs are registered; the values below are what they take after
  // the coming edge. ph counts clocks within a bit-period: SCLK is driven
  // low for ph < SCLK_HALF and high for the rest, and data is captured on
  // the edge that raises SCLK.
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    ph_d      = ph;
    shift_d   = shift;
    cs_n_d    = adc_cs_n_o;
    sclk_d    = adc_sclk_o;
    sample_d  = sample_o;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    case (state)
      IDLE: begin
        if (tick && en_i) begin
          cs_n_d  = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d   = SHIFT;
        bit_cnt_d = '0;
        ph_d      = '0;
        sclk_d    = 1'b0;
      end
      SHIFT: begin
        if (ph == PH_LAST) begin
          if (bit_cnt == 4'd15) begin
            cs_n_d   = 1'b1;
            sclk_d   = 1'b1;
            sample_d = shift[11:0];
            valid_d  = 1'b1;
            err_d    = |shift[15:12];
            state_d  = IDLE;
          end else begin
            bit_cnt_d = bit_cnt + 4'd1;
            ph_d      = '0;
            sclk_d    = 1'b0;
          end
        end else begin
          ph_d = ph + PH_W'(1);
          if (ph_d == PH_RISE) begin
            sclk_d  = 1'b1;
            shift_d = {shift[14:0], adc_sdata_i};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_adc_spi_capture.sv
// tb_adc_spi_capture
//   Two instances: inst[0] at default parameters, inst[1] with SCLK_HALF=2
//   and CLK_FREQ=100 MHz. Each has an ADC serial model fed from a word table
//   and a frame-timing model that predicts every output on every cycle from
//   the number of edges since the frame's tick.
`timescale 1ns/1ps
module tb_adc_spi_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en [2] = '{1'b0, 1'b0};
  logic [15:0] words [2][256];
  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned fails  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int H  = (g == 0) ? 1 : 2;
    localparam int CF = (g == 0) ? 50_000_000 : 100_000_000;
    localparam int P  = CF / 1_000_000;
    localparam int L  = 32 * H;

    logic        sdata = 1'b0;
    logic        cs_n, sclk, valid, err;
    logic [11:0] sample;

    adc_spi_capture #(
      .CLK_FREQ (CF),
      .SAMP_RATE(1_000_000),
      .SCLK_HALF(H)
    ) dut (
      .clk           (clk),
      .rst           (rst),
      .en_i          (en[g]),
      .adc_sdata_i   (sdata),
      .adc_cs_n_o    (cs_n),
      .adc_sclk_o    (sclk),
      .sample_o      (sample),
      .sample_valid_o(valid),
      .frame_err_o   (err)
    );

    // ADC: latches the next table word when CS_N falls (SCLK is high then),
    // and presents one bit per SCLK falling edge, MSB first.
    logic [15:0] cur = '0;
    int          nfall = 0;
    int unsigned drv_frame = 0;
    always @(negedge cs_n or negedge sclk) begin
      if (sclk) begin
        cur = words[g][drv_frame[7:0]];
        drv_frame++;
        nfall = 0;
      end else if (!cs_n && nfall < 16) begin
        sdata = cur[15 - nfall];
        nfall++;
      end
    end

    // Frame model: n counts edges since reset release; edge n is a tick when
    // (n-1) is a multiple of P. A frame starting at edge s holds CS_N low
    // after edges s..s+L, drives SCLK per bit-period after edges s+1..s+L,
    // and strobes after edge s+L+1.
    int          n = 0, s = -1000, d = 0;
    int unsigned mframe = 0;
    logic [15:0] mword = '0;
    logic        e_cs_n = 1'b1, e_sclk = 1'b1, e_valid = 1'b0, e_err = 1'b0;
    logic [11:0] e_sample = '0;
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        n = 0; s = -1000;
        e_cs_n = 1'b1; e_sclk = 1'b1; e_valid = 1'b0; e_err = 1'b0; e_sample = '0;
      end else begin
        n++;
        if ((n - 1) % P == 0 && en[g] && (n - s) >= L + 2) begin
          s = n;
          mword = words[g][mframe[7:0]];
          mframe++;
        end
        d = n - s;
        e_cs_n  = !(d <= L);
        e_sclk  = (d >= 1 && d <= L) ? (((d - 1) % (2 * H)) >= H) : 1'b1;
        e_valid = (d == L + 1);
        e_err   = e_valid && (mword[15:12] != 4'h0);
        if (e_valid) e_sample = mword[11:0];
      end
    end

    int          low_cnt = 0, rises = 0;
    logic        pcs = 1'b1, psclk = 1'b1;
    int unsigned vcount = 0, vtime = 0;
    logic [11:0] vcode = '0;
    logic        verr = 1'b0;
    always @(negedge clk) begin
      chk($sformatf("inst%0d {cs_n,sclk,valid,err,sample}", g),
          {16'h0, cs_n, sclk, valid, err, sample},
          {16'h0, e_cs_n, e_sclk, e_valid, e_err, e_sample});
      if (!rst) begin
        low_cnt = 0; rises = 0;
      end else if (!cs_n) begin
        low_cnt++;
        if (sclk && !psclk) rises++;
      end else if (!pcs) begin
        chk($sformatf("inst%0d cs_n low cycles", g), low_cnt, 1 + L);
        chk($sformatf("inst%0d sclk rising edges", g), rises, 16);
        low_cnt = 0; rises = 0;
      end
      if (valid) begin
        vcount++; vtime = cyc; vcode = sample; verr = err;
      end
      pcs = cs_n; psclk = sclk;
    end
  end

  task automatic snap(input int g, output int unsigned vc, output int unsigned vt,
                      output logic [11:0] code, output logic ferr, output logic cs);
    if (g == 0) begin
      vc = inst[0].vcount; vt = inst[0].vtime; code = inst[0].vcode; ferr = inst[0].verr; cs = inst[0].cs_n;
    end else begin
      vc = inst[1].vcount; vt = inst[1].vtime; code = inst[1].vcode; ferr = inst[1].verr; cs = inst[1].cs_n;
    end
  endtask

  task automatic wait_valid(input int g, input int limit, output logic [11:0] code,
                            output logic ferr, output int unsigned t);
    int unsigned c0, vc, vt;
    logic [11:0] vcd;
    logic ve, cs;
    snap(g, c0, vt, vcd, ve, cs);
    vc = c0;
    for (int i = 0; i < limit && vc == c0; i++) begin
      @(negedge clk); #1;
      snap(g, vc, vt, vcd, ve, cs);
    end
    chk($sformatf("inst%0d strobe within %0d cycles", g, limit), 32'(vc != c0), 1);
    code = vcd; ferr = ve; t = vt;
  endtask

  task automatic wait_cs_low(input int g, input int limit, output int unsigned t);
    int unsigned vc, vt;
    logic [11:0] vcd;
    logic ve, cs;
    snap(g, vc, vt, vcd, ve, cs);
    for (int i = 0; i < limit && cs; i++) begin
      @(negedge clk); #1;
      snap(g, vc, vt, vcd, ve, cs);
    end
    chk($sformatf("inst%0d cs_n falls within %0d cycles", g, limit), 32'(cs), 0);
    t = cyc;
  endtask

  initial begin
    logic [11:0] code;
    logic        ferr, cs;
    int unsigned t, tp, c0, v, vc0, vc1, vt;

    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 256; i++) words[g][i] = '0;
    words[0][0] = 16'h0ABC;
    for (int i = 0; i < 100; i++) words[0][i + 1] = 16'(i);
    words[0][101] = 16'hF800;
    words[0][102] = 16'h0123;
    words[0][103] = 16'h0555;
    words[0][104] = 16'h0321;
    words[0][105] = 16'h0777;
    words[0][106] = 16'h0246;
    words[1][0]   = 16'h0000;
    words[1][1]   = 16'h0FFF;
    words[1][2]   = 16'h0A5A;

    en[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset outputs inst0", {16'h0, inst[0].cs_n, inst[0].sclk, inst[0].valid, inst[0].err, inst[0].sample}, 32'h0000_C000);

    // Basic capture: tick on the first edge, strobe 34 cycles after release.
    rst = 1'b1;
    c0  = cyc;
    wait_valid(0, 60, code, ferr, t);
    chk("basic code", code, 12'hABC);
    chk("basic err", ferr, 0);
    chk("basic latency", t - c0, 34);

    // Rate and continuity.
    tp = t;
    for (int i = 0; i < 100; i++) begin
      wait_valid(0, 60, code, ferr, t);
      chk("count code", code, 12'(i));
      chk("count spacing", t - tp, 50);
      tp = t;
    end

    // Frame error does not suppress the sample.
    wait_valid(0, 60, code, ferr, t);
    chk("err frame code", code, 12'h800);
    chk("err frame flag", ferr, 1);
    wait_valid(0, 60, code, ferr, t);
    chk("post-err code", code, 12'h123);
    chk("post-err flag", ferr, 0);

    // Enable gating: drop en during bit 5, frame still completes.
    wait_cs_low(0, 60, t);
    repeat (11) @(negedge clk);
    en[0] = 1'b0;
    wait_valid(0, 60, code, ferr, t);
    chk("gated code", code, 12'h555);
    v = t;
    snap(0, vc0, vt, code, ferr, cs);
    repeat (120) @(negedge clk);
    snap(0, vc1, vt, code, ferr, cs);
    chk("no strobe while disabled", vc1, vc0);
    en[0] = 1'b1;
    // Ticks sit at v-33+50k, so the first one after v+120 is v+167.
    wait_cs_low(0, 60, t);
    chk("re-enable cs fall", t, v + 167);
    wait_valid(0, 60, code, ferr, t);
    chk("re-enable code", code, 12'h321);

    // Async reset mid-SHIFT.
    wait_cs_low(0, 60, t);
    repeat (6) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async reset outputs", {16'h0, inst[0].cs_n, inst[0].sclk, inst[0].valid, inst[0].err, inst[0].sample}, 32'h0000_C000);
    snap(0, vc0, vt, code, ferr, cs);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    c0  = cyc;
    @(posedge clk); #1;
    chk("cs falls on first edge after reset", inst[0].cs_n, 0);
    snap(0, vc1, vt, code, ferr, cs);
    chk("no strobe from aborted frame", vc1, vc0);
    wait_valid(0, 60, code, ferr, t);
    chk("post-reset code", code, 12'h246);
    chk("post-reset latency", t - c0, 34);
    en[0] = 1'b0;

    // Slower SCLK instance.
    en[1] = 1'b1;
    wait_valid(1, 250, code, ferr, t);
    chk("slow code 000", code, 12'h000);
    chk("slow err", ferr, 0);
    tp = t;
    wait_valid(1, 150, code, ferr, t);
    chk("slow code FFF", code, 12'hFFF);
    chk("slow spacing 1", t - tp, 100);
    tp = t;
    wait_valid(1, 150, code, ferr, t);
    chk("slow code A5A", code, 12'hA5A);
    chk("slow spacing 2", t - tp, 100);
    en[1] = 1'b0;

    repeat (20) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
